// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - automatic player: watches the game's LED sequence and replays it on the buttons
module jogador_automatico #(
   parameter int HOLD = 4,
   parameter int GAP  = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ativo,
   input  logic [3:0] leds,
   input  logic       espera_jogada,
   input  logic       pronto,
   input  logic       acertou,
   output logic       iniciar,
   output logic [3:0] botoes,
   output logic       fim,
   output logic       venceu,
   output logic       overflow,
   output logic [2:0] db_estado,
   output logic [4:0] db_contagem
);

   localparam int CW = $clog2(HOLD + GAP + 1);
   localparam logic [CW-1:0] HOLD_INI = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_INI  = CW'(GAP - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] START   = 3'd1;
   localparam logic [2:0] OBSERVA = 3'd2;
   localparam logic [2:0] PRESS   = 3'd3;
   localparam logic [2:0] RELEASE = 3'd4;
   localparam logic [2:0] FIM     = 3'd5;

   logic [2:0]    estado;
   logic [4:0]    wr;
   logic [4:0]    rd;
   logic [4:0]    rd_prox;
   logic [CW-1:0] cnt;
   logic [3:0]    leds_prev;
   logic [3:0]    mem [0:15];
   logic          captura;

   // A capture is the rising edge of "something shown": blank -> nonzero.
   assign captura     = (estado == OBSERVA) && (leds != 4'd0) && (leds_prev == 4'd0);
   assign rd_prox     = rd + 5'd1;
   assign db_estado   = estado;
   assign db_contagem = wr;

   always_ff @(posedge clock) begin
      if (captura && !wr[4])
         mem[wr[3:0]] <= leds;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado    <= IDLE;
         wr        <= 5'd0;
         rd        <= 5'd0;
         cnt       <= '0;
         leds_prev <= 4'd0;
         iniciar   <= 1'b0;
         botoes    <= 4'd0;
         fim       <= 1'b0;
         venceu    <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         iniciar <= 1'b0;
         case (estado)
            IDLE: begin
               botoes <= 4'd0;
               fim    <= 1'b0;
               venceu <= 1'b0;
               if (ativo) begin
                  estado  <= START;
                  iniciar <= 1'b1;
               end
            end
            START: begin
               wr        <= 5'd0;
               rd        <= 5'd0;
               overflow  <= 1'b0;
               leds_prev <= 4'd0;
               estado    <= ativo ? OBSERVA : IDLE;
            end
            OBSERVA: begin
               leds_prev <= leds;
               if (captura) begin
                  if (wr[4])
                     overflow <= 1'b1;
                  else
                     wr <= wr + 5'd1;
               end
               if (pronto) begin
                  estado <= FIM;
                  fim    <= 1'b1;
                  venceu <= acertou;
               end else if (!ativo) begin
                  estado <= IDLE;
               end else if (espera_jogada && (wr != 5'd0)) begin
                  rd     <= 5'd0;
                  cnt    <= HOLD_INI;
                  botoes <= mem[0];
                  estado <= PRESS;
               end
            end
            PRESS: begin
               if (pronto) begin
                  estado <= FIM;
                  fim    <= 1'b1;
                  venceu <= acertou;
                  botoes <= 4'd0;
               end else if (!ativo) begin
                  estado <= IDLE;
                  botoes <= 4'd0;
               end else if (cnt == '0) begin
                  cnt    <= GAP_INI;
                  botoes <= 4'd0;
                  estado <= RELEASE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RELEASE: begin
               botoes <= 4'd0;
               if (pronto) begin
                  estado <= FIM;
                  fim    <= 1'b1;
                  venceu <= acertou;
               end else if (!ativo) begin
                  estado <= IDLE;
               end else if (cnt == '0) begin
                  rd <= rd_prox;
                  // Last stored play done: empty the buffer and watch for the next round.
                  if (rd_prox == wr) begin
                     wr        <= 5'd0;
                     leds_prev <= 4'd0;
                     estado    <= OBSERVA;
                  end else begin
                     cnt    <= HOLD_INI;
                     botoes <= mem[rd_prox[3:0]];
                     estado <= PRESS;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            FIM: begin
               botoes <= 4'd0;
               if (!ativo) begin
                  estado <= IDLE;
                  fim    <= 1'b0;
                  venceu <= 1'b0;
               end
            end
            default: begin
               estado <= IDLE;
               botoes <= 4'd0;
               fim    <= 1'b0;
               venceu <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jogador_automatico.sv
// tb/tb_jogador_automatico.sv - scoreboard bench for jogador_automatico with randomized game rounds
module tb_jogador_automatico;

   localparam int HOLD = 4;
   localparam int GAP  = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ativo = 1'b0;
   logic [3:0] leds = 4'd0;
   logic       espera_jogada = 1'b0;
   logic       pronto = 1'b0;
   logic       acertou = 1'b0;
   logic       iniciar;
   logic [3:0] botoes;
   logic       fim;
   logic       venceu;
   logic       overflow;
   logic [2:0] db_estado;
   logic [4:0] db_contagem;

   jogador_automatico #(.HOLD(HOLD), .GAP(GAP)) dut (
      .clock(clock), .reset(reset), .ativo(ativo), .leds(leds),
      .espera_jogada(espera_jogada), .pronto(pronto), .acertou(acertou),
      .iniciar(iniciar), .botoes(botoes), .fim(fim), .venceu(venceu),
      .overflow(overflow), .db_estado(db_estado), .db_contagem(db_contagem)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail = 0;
   int presses = 0;
   bit len_chk = 1'b1;
   int exp_q[$];
   logic [3:0] shown[$];

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic tick();
      @(negedge clock);
   endtask

   // Monitor: every press start pops the scoreboard, every press end checks its length.
   initial begin : monitor
      logic [3:0] prev;
      int run;
      prev = 4'd0;
      run = 0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev = 4'd0;
            run = 0;
         end else begin
            if (botoes != 4'd0 && prev == 4'd0) begin
               presses++;
               if (exp_q.size() == 0)
                  check("unexpected_press", int'(botoes), 0);
               else
                  check("press_value", int'(botoes), exp_q.pop_front());
               run = 1;
            end else if (botoes != 4'd0) begin
               run++;
            end else if (prev != 4'd0) begin
               if (len_chk && !fim)
                  check("press_len", run, HOLD);
               run = 0;
            end
            prev = botoes;
         end
      end
   end

   task automatic start_game();
      ativo = 1'b1;
      tick();
      check("iniciar_high", int'(iniciar), 1);
      check("state_start", int'(db_estado), 1);
      tick();
      check("iniciar_low", int'(iniciar), 0);
      check("state_observa", int'(db_estado), 2);
      check("count_start", int'(db_contagem), 0);
      check("overflow_cleared", int'(overflow), 0);
      shown.delete();
   endtask

   task automatic show(input logic [3:0] v, input int on, input int off);
      leds = v;
      shown.push_back(v);
      tick();
      check("capture_count", int'(db_contagem), imin(shown.size(), 16));
      check("overflow_flag", int'(overflow), int'(shown.size() > 16));
      repeat (on - 1) tick();
      leds = 4'd0;
      repeat (off) tick();
      check("count_held", int'(db_contagem), imin(shown.size(), 16));
   endtask

   task automatic replay();
      int n;
      int p0;
      int k;
      bit seen;
      n = imin(shown.size(), 16);
      for (int i = 0; i < n; i++) exp_q.push_back(int'(shown[i]));
      p0 = presses;
      k = 0;
      seen = 1'b0;
      espera_jogada = 1'b1;
      while (k < 1000) begin
         @(posedge clock);
         k++;
         @(negedge clock);
         if (db_estado == 3'd3) seen = 1'b1;
         if (seen && db_estado == 3'd2) break;
      end
      espera_jogada = 1'b0;
      check("round_cycles", k, 1 + n * (HOLD + GAP));
      check("press_count", presses - p0, n);
      check("count_cleared", int'(db_contagem), 0);
      check("scoreboard_empty", exp_q.size(), 0);
      exp_q.delete();
      shown.delete();
   endtask

   task automatic stop_game();
      ativo = 1'b0;
      tick();
      check("state_idle", int'(db_estado), 0);
      check("fim_cleared", int'(fim), 0);
      check("venceu_cleared", int'(venceu), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int p0;
      int rises;
      int k;
      logic [3:0] pb;
      logic [3:0] v;

      repeat (3) tick();
      check("rst_state", int'(db_estado), 0);
      check("rst_botoes", int'(botoes), 0);
      check("rst_iniciar", int'(iniciar), 0);
      check("rst_fim_venceu_ovf", int'({fim, venceu, overflow}), 0);
      check("rst_count", int'(db_contagem), 0);
      reset = 1'b1;
      tick();

      // Single round from the test plan
      start_game();
      show(4'b0001, 10, 5);
      show(4'b0100, 10, 3);
      replay();
      check("single_round_state", int'(db_estado), 2);
      stop_game();

      // Two rounds, then the game reports a win while observing
      start_game();
      p0 = presses;
      show(4'b1000, 3, 2);
      replay();
      show(4'b1000, 3, 2);
      show(4'b0010, 3, 2);
      replay();
      pronto = 1'b1;
      acertou = 1'b1;
      tick();
      check("win_fim", int'(fim), 1);
      check("win_venceu", int'(venceu), 1);
      check("win_state", int'(db_estado), 5);
      check("win_presses", presses - p0, 3);
      pronto = 1'b0;
      acertou = 1'b0;
      tick();
      check("venceu_latched", int'(venceu), 1);
      stop_game();

      // Randomized rounds with arbitrary (possibly non one-hot) patterns
      start_game();
      repeat (3) begin
         int n;
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            v = 4'($urandom_range(1, 15));
            show(v, $urandom_range(1, 5), $urandom_range(1, 4));
         end
         replay();
      end
      stop_game();

      // Game error during the second press
      start_game();
      show(4'b0001, 2, 1);
      show(4'b0100, 2, 1);
      show(4'b0010, 2, 1);
      for (int i = 0; i < 3; i++) exp_q.push_back(int'(shown[i]));
      espera_jogada = 1'b1;
      rises = 0;
      pb = 4'd0;
      k = 0;
      while (rises < 2 && k < 200) begin
         tick();
         k++;
         if (botoes != 4'd0 && pb == 4'd0) rises++;
         pb = botoes;
      end
      check("err_second_press_seen", rises, 2);
      pronto = 1'b1;
      acertou = 1'b0;
      tick();
      check("err_botoes", int'(botoes), 0);
      check("err_fim", int'(fim), 1);
      check("err_venceu", int'(venceu), 0);
      exp_q.delete();
      espera_jogada = 1'b0;
      pronto = 1'b0;
      tick();
      check("err_fim_held", int'(fim), 1);
      stop_game();

      // Overflow: 17 shown, 16 replayed; then empty wait and abort
      start_game();
      for (int i = 0; i < 17; i++) begin
         v = 4'(1 << $urandom_range(0, 3));
         show(v, $urandom_range(1, 3), 1);
      end
      replay();
      check("ovf_sticky", int'(overflow), 1);
      p0 = presses;
      espera_jogada = 1'b1;
      repeat (5) begin
         tick();
         check("empty_wait_state", int'(db_estado), 2);
      end
      check("empty_wait_presses", presses - p0, 0);
      espera_jogada = 1'b0;
      stop_game();
      check("ovf_in_idle", int'(overflow), 1);
      start_game();

      // Asynchronous reset mid-press
      show(4'b0010, 3, 2);
      exp_q.push_back(2);
      espera_jogada = 1'b1;
      k = 0;
      while (botoes != 4'b0010 && k < 100) begin
         tick();
         k++;
      end
      check("rst_press_reached", int'(botoes), 2);
      #2;
      len_chk = 1'b0;
      reset = 1'b0;
      #1;
      check("async_rst_botoes", int'(botoes), 0);
      check("async_rst_state", int'(db_estado), 0);
      repeat (3) begin
         @(posedge clock);
         #1;
         check("rst_hold_outputs", int'({botoes, iniciar, fim, venceu, overflow, db_estado, db_contagem}), 0);
      end
      exp_q.delete();
      espera_jogada = 1'b0;
      ativo = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jogador_automatico.md
# jogador_automatico

Automatic player for the memory-game datapath/control pair. It pulses `iniciar`, watches the LED pattern the game shows, and stores each shown position in a 16-entry buffer. When the game waits for plays, it replays the stored sequence on the button inputs with fixed press and release timing. It sits outside the game top level, wired LED-out to `leds` and `botoes` to button-in, and is used for self-test and regression of full rounds.

## Interface
- `HOLD`, default 4: cycles each button is held active (≥1).
- `GAP`, default 4: cycles of all-zero buttons after each press (≥1).
- `clock` in 1: single system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0), forces IDLE.
- `ativo` in 1: level; 1 lets the player start and run a game.
- `leds` in 4: game LED output; one-hot while a position is shown, 0000 while blank.
- `espera_jogada` in 1: level from game; 1 while the game waits for a play.
- `pronto` in 1: game finished.
- `acertou` in 1: game won, valid with `pronto`.
- `iniciar` out 1: one-cycle start pulse to the game.
- `botoes` out 4: button pattern driven into the game.
- `fim` out 1: level; player reached FIM.
- `venceu` out 1: copy of `acertou` registered on entry to FIM.
- `overflow` out 1: sticky; more than 16 positions shown in one round.
- `db_estado` out 3: current state code.
- `db_contagem` out 5: number of entries stored in the current round (0..16).

## Operation
- Reset values:
  - `iniciar`, `botoes`, `fim`, `venceu`, `overflow` = 0.
  - `db_estado` = IDLE (0), `db_contagem` = 0.
  - Write pointer `wr` = 0, read pointer `rd` = 0.
  - Hold/gap counter = 0, `leds_prev` = 0.
  - Buffer contents are don't-care.
- States and codes: IDLE 0, START 1, OBSERVA 2, PRESS 3, RELEASE 4, FIM 5.
- IDLE: go to START when `ativo`=1.
- START: `iniciar`=1 for exactly this cycle. Clear `wr`, `rd`, `overflow`. Go to OBSERVA.
- OBSERVA (capture):
  - `leds_prev` <= `leds` every cycle in this state.
  - Capture on `leds`≠0 while `leds_prev`=0: write `leds` into mem[`wr`] and increment `wr`.
  - Patterns that are not one-hot are stored unchanged; no checking.
  - Capture with `wr`=16: entry dropped, `overflow` <= 1, `wr` stays 16.
- OBSERVA (exits, priority order):
  - `pronto`=1: go to FIM.
  - `ativo`=0: go to IDLE.
  - `espera_jogada`=1 and `wr`>0: set `rd`=0, load counter = HOLD-1, go to PRESS.
  - `espera_jogada`=1 and `wr`=0: stay in OBSERVA.
- PRESS:
  - `botoes` = mem[`rd`], registered output.
  - Count down; at 0, load counter = GAP-1 and go to RELEASE.
- RELEASE:
  - `botoes` = 0; count down.
  - At 0, increment `rd`.
  - If the new `rd` = `wr`: clear `wr`, set `leds_prev`=0, go to OBSERVA for the next round.
  - Otherwise: load counter = HOLD-1 and go to PRESS.
- `pronto`=1 in PRESS or RELEASE: go to FIM immediately and drive `botoes`=0. This covers the game detecting an error mid-replay.
- FIM:
  - `fim`=1; `venceu` = `acertou` sampled on the entry cycle.
  - Stay until `ativo`=0, then go to IDLE (`fim`, `venceu` cleared).
- `ativo`=0 in any state other than FIM: go to IDLE next cycle, `botoes`=0.
- `wr`, `rd` are 5-bit. The buffer is addressed by `rd[3:0]`, always with `rd` < `wr` ≤ 16. No wrap-around.

## Timing
- All outputs are registered; each changes on the clock edge that enters its state.
- `iniciar`: high exactly 1 cycle, 1 cycle after `ativo` is seen high in IDLE.
- Capture latency: `leds` becomes nonzero at cycle t; stored, and `db_contagem` increments, at edge t+1.
- A pattern held for many cycles counts once. Two shown positions need ≥1 blank cycle between them.
- PRESS → button latency: `espera_jogada` seen high at edge t; `botoes` valid from edge t+1.
- Each play lasts HOLD+GAP cycles. A round of N plays takes N·(HOLD+GAP) cycles.
- `pronto` seen at edge t: `fim`=1 and `botoes`=0 from edge t+1.
- Asynchronous reset asserted mid-PRESS: `botoes`=0 immediately, not waiting for a clock edge.

## Test plan
- Reset in PRESS with `botoes`=0010: drive `reset`=0 between edges → `botoes`=0000 and `db_estado`=0 before the next edge. Hold `reset`=0 three more edges → outputs unchanged.
- Single round:
  - Stimulus: `ativo`=1, one `iniciar` pulse; `leds` shows 0001 for 10 cycles, 0000 for 5, 0100 for 10, 0000; then `espera_jogada`=1.
  - Response: `db_contagem`=2. `botoes`=0001 for 4 cycles, 0000 for 4, 0100 for 4, 0000 for 4. Then `db_estado`=2 and `db_contagem`=0.
- Two rounds then win: show 1000, replay; show 1000, 0010, replay; `pronto`=1, `acertou`=1 → `fim`=1, `venceu`=1, 3 total presses in correct order.
- Mid-replay error: `pronto`=1 with `acertou`=0 during the second PRESS → `botoes`=0000 next cycle, `fim`=1, `venceu`=0.
- Overflow: show 17 positions → `db_contagem`=16, `overflow`=1. Replay has exactly 16 presses, matching the first 16 shown values.
- Empty wait and abort: `espera_jogada`=1 with `wr`=0 → stays in OBSERVA, no presses. Then `ativo`=0 → IDLE next cycle. Then `ativo`=1 → new `iniciar` pulse and `overflow` cleared.
